// File: rtl/rot_axi_boundary_pkg.sv
// Shared types for the RoT outbound AXI boundary: isolation FSM states, counter
// width helper and the default 32-bit / 64-bit address AXI channel structs.
package rot_axi_boundary_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } iso_state_e;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiIdW       = 8;
  localparam int unsigned AxiUserW     = 1;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [2:0]          prot;
    logic [AxiUserW-1:0] user;
  } axi32_ax_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [63:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [2:0]          prot;
    logic [AxiUserW-1:0] user;
  } axi64_ax_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserW-1:0]       user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [1:0]          resp;
    logic [AxiUserW-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]       id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserW-1:0]     user;
  } axi_r_chan_t;

  typedef struct packed {
    axi32_ax_chan_t aw;
    logic           aw_valid;
    axi_w_chan_t    w;
    logic           w_valid;
    logic           b_ready;
    axi32_ax_chan_t ar;
    logic           ar_valid;
    logic           r_ready;
  } axi32_req_t;

  typedef struct packed {
    axi64_ax_chan_t aw;
    logic           aw_valid;
    axi_w_chan_t    w;
    logic           w_valid;
    logic           b_ready;
    axi64_ax_chan_t ar;
    logic           ar_valid;
    logic           r_ready;
  } axi64_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    axi_b_chan_t b;
    logic        b_valid;
    axi_r_chan_t r;
    logic        r_valid;
  } axi_rsp_t;

endpackage

// File: rtl/rot_axi_txn_counter.sv
// Saturating up/down outstanding-transaction counter; simultaneous inc and dec
// cancel out.
module rot_axi_txn_counter
  import rot_axi_boundary_pkg::*;
#(
  parameter int unsigned Max = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic max_o,
  output logic zero_o
);

  localparam int unsigned W = cnt_w(Max);

  logic [W-1:0] cnt_d, cnt_q;

  assign max_o  = (cnt_q == W'(Max));
  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !max_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A compliant master side never retires more than it issued, and the
  // admission gate never lets the count pass Max.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(dec_i && !inc_i && zero_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(inc_i && !dec_i && max_o));

endmodule

// File: rtl/rot_axi_boundary.sv
// AXI boundary after the RoT data-width converter: extends addresses with a
// window register, caps outstanding bursts and implements drain-then-fence isolation.
module rot_axi_boundary
  import rot_axi_boundary_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiIdWidth   = 8,
  parameter int unsigned MaxWrTxns    = 8,
  parameter int unsigned MaxRdTxns    = 8,
  parameter type slv_req_t = axi32_req_t,
  parameter type slv_rsp_t = axi_rsp_t,
  parameter type mst_req_t = axi64_req_t,
  parameter type mst_rsp_t = axi_rsp_t,
  localparam int unsigned HiW = (AxiAddrWidth > 32) ? AxiAddrWidth - 32 : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  slv_req_t       slv_req_i,
  output slv_rsp_t       slv_rsp_o,
  output mst_req_t       mst_req_o,
  input  mst_rsp_t       mst_rsp_i,
  input  logic [HiW-1:0] addr_hi_i,
  input  logic           isolate_req_i,
  output logic           isolate_ack_o,
  output logic           busy_o
);

  iso_state_e                state_d, state_q;
  logic                      iso_ack_q;
  logic [HiW-1:0]            addr_hi_d, addr_hi_q;
  logic [AxiAddrWidth-1:0]   aw_addr_ext, ar_addr_ext;
  logic wr_max, wr_zero, rd_max, rd_zero, wp_max, wp_zero, all_zero;
  logic aw_open, ar_open, w_open;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

  assign all_zero = wr_zero && rd_zero && wp_zero;
  assign busy_o   = !all_zero;

  // valid/ready: a beat transfers when valid && ready in the same cycle. The
  // AW/AR gates depend only on registered state, so gating valid and ready with
  // the same term keeps both sides consistent; W may open on a same-cycle AW.
  assign aw_open   = (state_q == RUN) && !wr_max;
  assign ar_open   = (state_q == RUN) && !rd_max;
  assign aw_hs     = slv_req_i.aw_valid && aw_open && mst_rsp_i.aw_ready;
  assign ar_hs     = slv_req_i.ar_valid && ar_open && mst_rsp_i.ar_ready;
  assign w_open    = !wp_zero || aw_hs;
  assign w_last_hs = slv_req_i.w_valid && w_open && mst_rsp_i.w_ready && slv_req_i.w.last;
  assign b_hs      = mst_rsp_i.b_valid && slv_req_i.b_ready;
  assign r_last_hs = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;

  rot_axi_txn_counter #(.Max(MaxWrTxns)) u_wr_cnt (
    .clk_i, .rst_ni, .inc_i(aw_hs), .dec_i(b_hs), .max_o(wr_max), .zero_o(wr_zero)
  );
  rot_axi_txn_counter #(.Max(MaxRdTxns)) u_rd_cnt (
    .clk_i, .rst_ni, .inc_i(ar_hs), .dec_i(r_last_hs), .max_o(rd_max), .zero_o(rd_zero)
  );
  rot_axi_txn_counter #(.Max(MaxWrTxns)) u_w_pend (
    .clk_i, .rst_ni, .inc_i(aw_hs), .dec_i(w_last_hs), .max_o(wp_max), .zero_o(wp_zero)
  );

  if (AxiAddrWidth > 32) begin : g_addr_ext
    assign aw_addr_ext = {addr_hi_q, slv_req_i.aw.addr};
    assign ar_addr_ext = {addr_hi_q, slv_req_i.ar.addr};
  end else begin : g_addr_pass
    assign aw_addr_ext = slv_req_i.aw.addr;
    assign ar_addr_ext = slv_req_i.ar.addr;
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = slv_req_i.aw.id;
    mst_req_o.aw.addr  = aw_addr_ext;
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw.prot  = slv_req_i.aw.prot;
    mst_req_o.aw.user  = slv_req_i.aw.user;
    mst_req_o.aw_valid = slv_req_i.aw_valid && aw_open;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid && w_open;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar.id    = slv_req_i.ar.id;
    mst_req_o.ar.addr  = ar_addr_ext;
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar.prot  = slv_req_i.ar.prot;
    mst_req_o.ar.user  = slv_req_i.ar.user;
    mst_req_o.ar_valid = slv_req_i.ar_valid && ar_open;
    mst_req_o.r_ready  = slv_req_i.r_ready;

    slv_rsp_o          = '0;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && aw_open;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && ar_open;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready && w_open;
    slv_rsp_o.b        = mst_rsp_i.b;
    slv_rsp_o.b_valid  = mst_rsp_i.b_valid;
    slv_rsp_o.r        = mst_rsp_i.r;
    slv_rsp_o.r_valid  = mst_rsp_i.r_valid;
  end

  // The window only moves while nothing is outstanding.
  assign addr_hi_d = all_zero ? addr_hi_i : addr_hi_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (isolate_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_req_i) state_d = RUN;
        else if (all_zero)  state_d = ISOLATED;
      end
      ISOLATED: if (!isolate_req_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      iso_ack_q <= 1'b0;
      addr_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      iso_ack_q <= (state_d == ISOLATED);
      addr_hi_q <= addr_hi_d;
    end
  end

  assign isolate_ack_o = iso_ack_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni) wp_max |-> wr_max);
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (AxiAddrWidth >= 32) && ($bits(slv_req_i.aw.id) == AxiIdWidth));

endmodule

// File: tb/tb_rot_axi_boundary.sv
// Directed bench for rot_axi_boundary: per-cycle write/isolation vector table
// plus hand-written read-limit, isolation-pulse, window and reset sequences.
module tb_rot_axi_boundary;
  import rot_axi_boundary_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  axi32_req_t  slv_req;
  axi_rsp_t    slv_rsp;
  axi64_req_t  mst_req;
  axi_rsp_t    mst_rsp;
  logic [31:0] addr_hi;
  logic        iso_req, iso_ack, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rot_axi_boundary #(
    .AxiAddrWidth(64), .AxiIdWidth(8), .MaxWrTxns(2), .MaxRdTxns(2),
    .slv_req_t(axi32_req_t), .slv_rsp_t(axi_rsp_t),
    .mst_req_t(axi64_req_t), .mst_rsp_t(axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req), .mst_rsp_i(mst_rsp),
    .addr_hi_i(addr_hi), .isolate_req_i(iso_req),
    .isolate_ack_o(iso_ack), .busy_o(busy)
  );

  typedef struct {
    bit awv, awr, wv, wl, wr, bv, iso;
    bit e_mawv, e_sawr, e_mwv, e_swr, e_busy, e_ack;
  } wvec_t;

  wvec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    slv_req = '0;
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;
    mst_rsp = '0;
    iso_req = 1'b0;
  endtask

  initial begin
    // Write/isolation script, one row per cycle, MaxWrTxns = 2.
    vecs[0]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0};
    vecs[1]  = '{0,0,1,0,1,0,0, 0,0,0,0,0,0};
    vecs[2]  = '{1,1,1,0,1,0,0, 1,1,1,1,0,0};
    vecs[3]  = '{1,0,1,1,1,0,0, 1,0,1,1,1,0};
    vecs[4]  = '{1,1,0,0,0,0,0, 1,1,0,0,1,0};
    vecs[5]  = '{1,1,1,1,1,0,0, 0,0,1,1,1,0};
    vecs[6]  = '{1,1,0,0,0,1,0, 0,0,0,0,1,0};
    vecs[7]  = '{1,1,0,0,0,0,0, 1,1,0,0,1,0};
    vecs[8]  = '{0,0,1,1,1,1,1, 0,0,1,1,1,0};
    vecs[9]  = '{1,1,1,1,1,1,1, 0,0,0,0,1,0};
    vecs[10] = '{1,1,0,0,0,0,1, 0,0,0,0,0,0};
    vecs[11] = '{1,1,1,1,1,0,1, 0,0,0,0,0,1};
    vecs[12] = '{1,1,0,0,0,0,0, 0,0,0,0,0,1};
    vecs[13] = '{1,1,0,0,0,0,0, 1,1,0,0,0,0};
    vecs[14] = '{0,0,1,1,1,1,0, 0,0,1,1,1,0};
    vecs[15] = '{0,0,0,0,0,0,0, 0,0,0,0,0,0};

    // Reset state.
    idle();
    addr_hi = 32'h0000_0001;
    slv_req.aw.addr = 32'h8000_0000;
    #12;
    chk("rst_ack", iso_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mst_awv", mst_req.aw_valid, 0);
    chk("rst_mst_wv", mst_req.w_valid, 0);
    chk("rst_mst_arv", mst_req.ar_valid, 0);
    chk("rst_slv_awr", slv_rsp.aw_ready, 0);
    chk("rst_slv_bv", slv_rsp.b_valid, 0);
    chk("rst_addr_hi", mst_req.aw.addr, 64'h0000_0000_8000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    next();
    next();

    // Single write with address extension and B pass-through.
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h8000_0000; slv_req.aw.id = 8'h5A;
    slv_req.w_valid = 1'b1; slv_req.w.data = 32'hCAFE_F00D; slv_req.w.last = 1'b1;
    mst_rsp.aw_ready = 1'b1; mst_rsp.w_ready = 1'b1;
    settle();
    chk("a_aw_addr", mst_req.aw.addr, 64'h1_8000_0000);
    chk("a_aw_id", mst_req.aw.id, 8'h5A);
    chk("a_mst_awv", mst_req.aw_valid, 1);
    chk("a_slv_awr", slv_rsp.aw_ready, 1);
    chk("a_mst_wv", mst_req.w_valid, 1);
    chk("a_w_data", mst_req.w.data, 32'hCAFE_F00D);
    next();
    idle();
    mst_rsp.b_valid = 1'b1; mst_rsp.b.id = 8'h5A; mst_rsp.b.resp = 2'b10;
    settle();
    chk("a_busy", busy, 1);
    chk("a_slv_bv", slv_rsp.b_valid, 1);
    chk("a_b_id", slv_rsp.b.id, 8'h5A);
    chk("a_b_resp", slv_rsp.b.resp, 2'b10);
    next();
    idle();
    settle();
    chk("a_busy_end", busy, 0);
    next();

    // Vector table.
    for (int i = 0; i < 16; i++) begin
      idle();
      slv_req.aw_valid = vecs[i].awv; mst_rsp.aw_ready = vecs[i].awr;
      slv_req.w_valid = vecs[i].wv; slv_req.w.last = vecs[i].wl;
      mst_rsp.w_ready = vecs[i].wr; mst_rsp.b_valid = vecs[i].bv;
      iso_req = vecs[i].iso;
      settle();
      chk($sformatf("v%0d_mst_awv", i), mst_req.aw_valid, vecs[i].e_mawv);
      chk($sformatf("v%0d_slv_awr", i), slv_rsp.aw_ready, vecs[i].e_sawr);
      chk($sformatf("v%0d_mst_wv", i), mst_req.w_valid, vecs[i].e_mwv);
      chk($sformatf("v%0d_slv_wr", i), slv_rsp.w_ready, vecs[i].e_swr);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_ack", i), iso_ack, vecs[i].e_ack);
      next();
    end

    // Read limit: third AR waits for the first R last, admitted the cycle after.
    idle();
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'h0000_4000; mst_rsp.ar_ready = 1'b1;
    settle();
    chk("b_ar_addr", mst_req.ar.addr, 64'h1_0000_4000);
    chk("b_arr1", slv_rsp.ar_ready, 1);
    next();
    settle();
    chk("b_arr2", slv_rsp.ar_ready, 1);
    next();
    mst_rsp.r_valid = 1'b1; mst_rsp.r.last = 1'b0;
    settle();
    chk("b_arr3_stall", slv_rsp.ar_ready, 0);
    chk("b_mst_arv3", mst_req.ar_valid, 0);
    next();
    mst_rsp.r.last = 1'b1; mst_rsp.r.data = 32'h1234_5678;
    settle();
    chk("b_arr4_stall", slv_rsp.ar_ready, 0);
    chk("b_slv_rv", slv_rsp.r_valid, 1);
    chk("b_r_data", slv_rsp.r.data, 32'h1234_5678);
    next();
    mst_rsp.r_valid = 1'b0;
    settle();
    chk("b_arr5_admit", slv_rsp.ar_ready, 1);
    chk("b_mst_arv5", mst_req.ar_valid, 1);
    next();
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid = 1'b1; mst_rsp.r.last = 1'b1;
    next();
    next();
    mst_rsp.r_valid = 1'b0;
    settle();
    chk("b_busy_end", busy, 0);
    next();

    // Three-cycle isolation pulse with one read outstanding.
    idle();
    slv_req.ar_valid = 1'b1; mst_rsp.ar_ready = 1'b1;
    next();
    slv_req.ar_valid = 1'b0;
    iso_req = 1'b1;
    settle();
    chk("c_ack1", iso_ack, 0);
    next();
    slv_req.ar_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("c_drain_arv%0d", k), mst_req.ar_valid, 0);
      chk($sformatf("c_drain_ack%0d", k), iso_ack, 0);
      next();
    end
    iso_req = 1'b0;
    settle();
    chk("c_drop_arv", mst_req.ar_valid, 0);
    chk("c_drop_ack", iso_ack, 0);
    next();
    settle();
    chk("c_run_arr", slv_rsp.ar_ready, 1);
    chk("c_run_ack", iso_ack, 0);
    next();
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid = 1'b1; mst_rsp.r.last = 1'b1;
    next();
    next();
    mst_rsp.r_valid = 1'b0;
    settle();
    chk("c_busy_end", busy, 0);
    next();

    // Window change under in-flight write.
    idle();
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h0000_1000; mst_rsp.aw_ready = 1'b1;
    settle();
    chk("d_addr_old", mst_req.aw.addr, 64'h1_0000_1000);
    next();
    addr_hi = 32'h0000_0002;
    mst_rsp.aw_ready = 1'b0;
    settle();
    chk("d_addr_held", mst_req.aw.addr, 64'h1_0000_1000);
    chk("d_busy", busy, 1);
    next();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1; mst_rsp.w_ready = 1'b1;
    next();
    slv_req.w_valid = 1'b0;
    mst_rsp.b_valid = 1'b1;
    settle();
    chk("d_busy_b", busy, 1);
    next();
    mst_rsp.b_valid = 1'b0;
    settle();
    chk("d_busy_fall", busy, 0);
    chk("d_addr_still_old", mst_req.aw.addr, 64'h1_0000_1000);
    next();
    slv_req.aw_valid = 1'b1; slv_req.aw.len = 8'd3; mst_rsp.aw_ready = 1'b1;
    settle();
    chk("d_addr_new", mst_req.aw.addr, 64'h2_0000_1000);
    chk("d_awr_new", slv_rsp.aw_ready, 1);
    next();

    // Reset in the middle of the 4-beat W burst.
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b0; mst_rsp.w_ready = 1'b1;
    settle();
    chk("e_mst_wv_pre", mst_req.w_valid, 1);
    chk("e_busy_pre", busy, 1);
    next();
    #1;
    rst_n = 1'b0;
    #1;
    chk("e_mst_wv_rst", mst_req.w_valid, 0);
    chk("e_slv_wr_rst", slv_rsp.w_ready, 0);
    chk("e_busy_rst", busy, 0);
    chk("e_ack_rst", iso_ack, 0);
    chk("e_addr_rst", mst_req.aw.addr, 64'h0_0000_1000);
    next();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    next();
    settle();
    chk("e_busy_after", busy, 0);
    chk("e_ack_after", iso_ack, 0);
    next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
